// File: rtl/atm_ledger.sv
// ============================================================================
// atm_ledger : multi-account ledger, one BALANCE/WITHDRAW/DEPOSIT/TRANSFER per
//              valid/ready request. Option macro: ATM_TXN_COUNT_EN (txn_count).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module atm_ledger #(
   parameter int NUM_ACCOUNTS = 16,
   parameter int ACCT_W       = 4,
   parameter int BAL_W        = 10,
   parameter int INIT_BALANCE = 200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ACCT_W-1:0] req_origin,
   input  logic [ACCT_W-1:0] req_purpose,
   input  logic [BAL_W-1:0]  req_amount,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_status,
   output logic [BAL_W-1:0]  rsp_balance
`ifdef ATM_TXN_COUNT_EN
   ,
   output logic [15:0]       txn_count
`endif
);

   localparam logic [2:0] OP_BALANCE  = 3'd0;
   localparam logic [2:0] OP_WITHDRAW = 3'd1;
   localparam logic [2:0] OP_DEPOSIT  = 3'd2;
   localparam logic [2:0] OP_TRANSFER = 3'd3;

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_INSUF = 2'b01;
   localparam logic [1:0] ST_OVFL  = 2'b10;
   localparam logic [1:0] ST_ERR   = 2'b11;

   localparam logic [ACCT_W:0]  NUM_ACCT_L = (ACCT_W+1)'(NUM_ACCOUNTS);
   localparam logic [BAL_W-1:0] INIT_BAL_L = BAL_W'(INIT_BALANCE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic [1:0]          rsp_status_q;
   logic [BAL_W-1:0]    rsp_balance_q;
   logic [2:0]          op_q;
   logic [ACCT_W-1:0]   origin_q;
   logic [ACCT_W-1:0]   purpose_q;
   logic [BAL_W-1:0]    amount_q;
   logic [BAL_W-1:0]    bal_q [NUM_ACCOUNTS];

   logic [BAL_W-1:0]    org_bal;
   logic [BAL_W-1:0]    dst_bal;
   logic                org_in;
   logic                pur_in;
   logic [BAL_W:0]      dep_sum;
   logic [BAL_W:0]      xfer_sum;
   logic [1:0]          status_d;
   logic [BAL_W-1:0]    org_new;
   logic [BAL_W-1:0]    dst_new;
   logic [BAL_W-1:0]    balance_d;
   logic                wr_org;
   logic                wr_dst;

   assign org_in   = ({1'b0, origin_q}  < NUM_ACCT_L);
   assign pur_in   = ({1'b0, purpose_q} < NUM_ACCT_L);
   assign dep_sum  = {1'b0, org_bal} + {1'b0, amount_q};
   assign xfer_sum = {1'b0, dst_bal} + {1'b0, amount_q};

   // Out-of-range accounts read as zero rather than indexing past the array.
   always_comb begin
      org_bal = '0;
      dst_bal = '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
         if (origin_q == ACCT_W'(i))  org_bal = bal_q[i];
         if (purpose_q == ACCT_W'(i)) dst_bal = bal_q[i];
      end
   end

   always_comb begin
      status_d = ST_OK;
      org_new  = org_bal;
      dst_new  = dst_bal;
      wr_org   = 1'b0;
      wr_dst   = 1'b0;
      if (op_q[2] || !org_in ||
          (op_q == OP_TRANSFER && (!pur_in || purpose_q == origin_q))) begin
         status_d = ST_ERR;
      end else begin
         case (op_q)
            OP_WITHDRAW: begin
               if (amount_q <= org_bal) begin
                  org_new = org_bal - amount_q;
                  wr_org  = 1'b1;
               end else begin
                  status_d = ST_INSUF;
               end
            end
            OP_DEPOSIT: begin
               if (dep_sum[BAL_W]) begin
                  status_d = ST_OVFL;
               end else begin
                  org_new = dep_sum[BAL_W-1:0];
                  wr_org  = 1'b1;
               end
            end
            OP_TRANSFER: begin
               if (amount_q > org_bal) begin
                  status_d = ST_INSUF;
               end else if (xfer_sum[BAL_W]) begin
                  status_d = ST_OVFL;
               end else begin
                  org_new = org_bal - amount_q;
                  dst_new = xfer_sum[BAL_W-1:0];
                  wr_org  = 1'b1;
                  wr_dst  = 1'b1;
               end
            end
            default: status_d = ST_OK;
         endcase
      end
      balance_d = (status_d == ST_ERR && !org_in) ? '0 : org_new;
   end

`ifdef ATM_TXN_COUNT_EN
   logic        count_inc;
   logic [15:0] txn_count_q;

   assign count_inc = (status_d == ST_OK) && (op_q != OP_BALANCE);
   assign txn_count = txn_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_count_q <= '0;
      end else if (state_q == S_EXEC && count_inc && txn_count_q != 16'hFFFF) begin
         txn_count_q <= txn_count_q + 16'd1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_status_q  <= ST_OK;
         rsp_balance_q <= '0;
         op_q          <= '0;
         origin_q      <= '0;
         purpose_q     <= '0;
         amount_q      <= '0;
         for (int i = 0; i < NUM_ACCOUNTS; i++) bal_q[i] <= INIT_BAL_L;
      end else begin
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_ready_q && req_valid) begin
                  op_q        <= req_op;
                  origin_q    <= req_origin;
                  purpose_q   <= req_purpose;
                  amount_q    <= req_amount;
                  req_ready_q <= 1'b0;
                  state_q     <= S_EXEC;
               end
            end
            S_EXEC: begin
               // Both legs of a transfer commit on this single edge.
               for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                  if (wr_org && origin_q == ACCT_W'(i))  bal_q[i] <= org_new;
                  if (wr_dst && purpose_q == ACCT_W'(i)) bal_q[i] <= dst_new;
               end
               rsp_status_q  <= status_d;
               rsp_balance_q <= balance_d;
               rsp_valid_q   <= 1'b1;
               state_q       <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_balance = rsp_balance_q;

endmodule

`default_nettype wire
